// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU issue controller: ALU_control/bonus_control
// codes, ALUOp and funct encodings, and the issue FSM state encoding.
// Optional feature macro: BONUS_CMP_EN (adds the bonus compare functs).
package alu_ctrl_pkg;

  // ALU_control codes understood by the lab ALU
  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_SLL  = 4'b1000;
  localparam logic [3:0] CTRL_SRL  = 4'b1001;
  localparam logic [3:0] CTRL_NOR  = 4'b1100;
  localparam logic [3:0] CTRL_NAND = 4'b1101;

  // bonus_control codes; only meaningful together with CTRL_SLT
  localparam logic [2:0] BONUS_SLT = 3'b000;
  localparam logic [2:0] BONUS_SGT = 3'b001;
  localparam logic [2:0] BONUS_SLE = 3'b010;
  localparam logic [2:0] BONUS_SGE = 3'b011;
  localparam logic [2:0] BONUS_SNE = 3'b100;
  localparam logic [2:0] BONUS_SEQ = 3'b110;

  // ALUOp from the main control unit
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_SLT   = 2'b11;

  // R-type funct field values
  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_NAND = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SGT  = 6'h38;
  localparam logic [5:0] FUNCT_SLE  = 6'h39;
  localparam logic [5:0] FUNCT_SGE  = 6'h3A;
  localparam logic [5:0] FUNCT_SEQ  = 6'h3B;
  localparam logic [5:0] FUNCT_SNE  = 6'h3C;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_issue_decode.sv
// Purpose: combinational ALUOp/funct -> {ALU_control, bonus_control, illegal}.
// Latency: 0 cycles (pure combinational).  Backpressure: none, no state.
// Ports: alu_op/funct in; control(4), bonus(3), illegal(1) out.
// Macro BONUS_CMP_EN enables the SGT/SLE/SGE/SEQ/SNE functs; without it
// they decode as illegal and bonus is always 000.
module alu_issue_decode (
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] control,
  output logic [2:0] bonus,
  output logic       illegal
);
  import alu_ctrl_pkg::*;

  always_comb begin
    control = CTRL_AND;
    bonus   = BONUS_SLT;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: control = CTRL_ADD;
      ALUOP_SUB: control = CTRL_SUB;
      ALUOP_SLT: control = CTRL_SLT;
      default: begin
        case (funct)
          FUNCT_ADD:  control = CTRL_ADD;
          FUNCT_SUB:  control = CTRL_SUB;
          FUNCT_AND:  control = CTRL_AND;
          FUNCT_OR:   control = CTRL_OR;
          FUNCT_NOR:  control = CTRL_NOR;
          FUNCT_NAND: control = CTRL_NAND;
          FUNCT_SLT:  control = CTRL_SLT;
          FUNCT_SLL:  control = CTRL_SLL;
          FUNCT_SRL:  control = CTRL_SRL;
`ifdef BONUS_CMP_EN
          FUNCT_SGT: begin control = CTRL_SLT; bonus = BONUS_SGT; end
          FUNCT_SLE: begin control = CTRL_SLT; bonus = BONUS_SLE; end
          FUNCT_SGE: begin control = CTRL_SLT; bonus = BONUS_SGE; end
          FUNCT_SEQ: begin control = CTRL_SLT; bonus = BONUS_SEQ; end
          FUNCT_SNE: begin control = CTRL_SLT; bonus = BONUS_SNE; end
`endif
          default:    illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Purpose: initiator side of the 32-bit ALU; decodes, issues one op, captures result.
// Latency: accept at edge N -> out_valid_o seen at edge N+2 (N+1 if illegal decode).
// Backpressure: in_ready_o only in IDLE; response held in DONE until out_ready_i.
// Ports: in_valid_i/in_ready_o request handshake with alu_op_i, funct_i, src1_i,
//   src2_i; alu_* drive the ALU and alu_result_i/zero/cout/overflow come back;
//   out_valid_o/out_ready_i response handshake with out_result_o and flags,
//   out_illegal_o; op_cnt_o counts accepted requests (wraps).
// Macro BONUS_CMP_EN (in alu_issue_decode) enables the bonus compare functs.
module alu_issue_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       alu_op_i,
  input  logic [5:0]       funct_i,
  input  logic [31:0]      src1_i,
  input  logic [31:0]      src2_i,
  output logic             alu_rst_n_o,
  output logic [31:0]      alu_src1_o,
  output logic [31:0]      alu_src2_o,
  output logic [3:0]       alu_control_o,
  output logic [2:0]       alu_bonus_o,
  input  logic [31:0]      alu_result_i,
  input  logic             alu_zero_i,
  input  logic             alu_cout_i,
  input  logic             alu_overflow_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_result_o,
  output logic             out_zero_o,
  output logic             out_cout_o,
  output logic             out_overflow_o,
  output logic             out_illegal_o,
  output logic [CNT_W-1:0] op_cnt_o
);
  import alu_ctrl_pkg::*;

  state_e     state_q;
  state_e     state_d;
  logic [3:0] dec_control;
  logic [2:0] dec_bonus;
  logic       dec_illegal;
  logic       accept;

  alu_issue_decode u_decode (
    .alu_op  (alu_op_i),
    .funct   (funct_i),
    .control (dec_control),
    .bonus   (dec_bonus),
    .illegal (dec_illegal)
  );

  // Ready is masked by reset so every output reads 0 while rst_i is high.
  assign in_ready_o  = (state_q == ST_IDLE) && !rst_i;
  assign accept      = in_valid_i && in_ready_o;
  // Decoded from the async-reset state register, so it drops with rst_i.
  assign out_valid_o = (state_q == ST_DONE);
  assign alu_rst_n_o = ~rst_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = dec_illegal ? ST_DONE : ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: if (out_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ALU-facing registers move only on a legal accept; an illegal op leaves
  // the ALU looking at the previous operation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alu_src1_o    <= '0;
      alu_src2_o    <= '0;
      alu_control_o <= CTRL_AND;
      alu_bonus_o   <= BONUS_SLT;
    end else if (accept && !dec_illegal) begin
      alu_src1_o    <= src1_i;
      alu_src2_o    <= src2_i;
      alu_control_o <= dec_control;
      alu_bonus_o   <= dec_bonus;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       op_cnt_o <= '0;
    else if (accept) op_cnt_o <= op_cnt_o + CNT_W'(1);
  end

  // Response capture: zeroed result on illegal accept, ALU sample at the
  // end of EXEC. Nothing changes in DONE, so out_* hold under backpressure.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_result_o   <= '0;
      out_zero_o     <= 1'b0;
      out_cout_o     <= 1'b0;
      out_overflow_o <= 1'b0;
      out_illegal_o  <= 1'b0;
    end else if (accept && dec_illegal) begin
      out_result_o   <= '0;
      out_zero_o     <= 1'b0;
      out_cout_o     <= 1'b0;
      out_overflow_o <= 1'b0;
      out_illegal_o  <= 1'b1;
    end else if (state_q == ST_EXEC) begin
      out_result_o   <= alu_result_i;
      out_zero_o     <= alu_zero_i;
      out_cout_o     <= alu_cout_i;
      out_overflow_o <= alu_overflow_i;
      out_illegal_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU on the alu_* side, an
// operation-level reference model, a per-cycle compare process, directed
// cases with literal expectations, then a randomized run.
module tb_alu_issue_ctrl;
  localparam int CW = 4;  // small counter so wrap-around is exercised

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [1:0]    alu_op_i = '0;
  logic [5:0]    funct_i = '0;
  logic [31:0]   src1_i = '0;
  logic [31:0]   src2_i = '0;
  logic          alu_rst_n_o;
  logic [31:0]   alu_src1_o, alu_src2_o;
  logic [3:0]    alu_control_o;
  logic [2:0]    alu_bonus_o;
  logic [31:0]   alu_result_i;
  logic          alu_zero_i, alu_cout_i, alu_overflow_i;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [31:0]   out_result_o;
  logic          out_zero_o, out_cout_o, out_overflow_o, out_illegal_o;
  logic [CW-1:0] op_cnt_o;

  int total = 0;
  int bad = 0;

  always #5 clk_i = ~clk_i;

  alu_issue_ctrl #(.CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .alu_op_i(alu_op_i), .funct_i(funct_i), .src1_i(src1_i), .src2_i(src2_i),
    .alu_rst_n_o(alu_rst_n_o), .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o),
    .alu_control_o(alu_control_o), .alu_bonus_o(alu_bonus_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i), .alu_cout_i(alu_cout_i),
    .alu_overflow_i(alu_overflow_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_result_o(out_result_o), .out_zero_o(out_zero_o), .out_cout_o(out_cout_o),
    .out_overflow_o(out_overflow_o), .out_illegal_o(out_illegal_o), .op_cnt_o(op_cnt_o)
  );

  // ---------------- operation semantics ----------------
  localparam int N_BAD = -1, N_AND = 0, N_OR = 1, N_ADD = 2, N_SUB = 3, N_SLT = 4,
                 N_NOR = 5, N_NAND = 6, N_SLL = 7, N_SRL = 8, N_SGT = 9, N_SLE = 10,
                 N_SGE = 11, N_SEQ = 12, N_SNE = 13, N_LAST = 13;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        c;
    logic        v;
  } alu_out_t;

  function automatic alu_out_t ref_calc(input int name, input logic [31:0] a, input logic [31:0] b);
    alu_out_t o;
    logic [32:0] w;
    o = '0;
    case (name)
      N_AND:  o.r = a & b;
      N_OR:   o.r = a | b;
      N_NOR:  o.r = ~(a | b);
      N_NAND: o.r = ~(a & b);
      N_ADD: begin
        w = {1'b0, a} + {1'b0, b};
        o.r = w[31:0]; o.c = w[32];
        o.v = (a[31] == b[31]) && (o.r[31] != a[31]);
      end
      N_SUB: begin
        w = {1'b0, a} + {1'b0, ~b} + 33'd1;
        o.r = w[31:0]; o.c = w[32];
        o.v = (a[31] != b[31]) && (o.r[31] != a[31]);
      end
      N_SLT:  o.r = {31'b0, $signed(a) <  $signed(b)};
      N_SGT:  o.r = {31'b0, $signed(a) >  $signed(b)};
      N_SLE:  o.r = {31'b0, $signed(a) <= $signed(b)};
      N_SGE:  o.r = {31'b0, $signed(a) >= $signed(b)};
      N_SEQ:  o.r = {31'b0, a == b};
      N_SNE:  o.r = {31'b0, a != b};
      N_SLL:  o.r = a << b[4:0];
      N_SRL:  o.r = a >> b[4:0];
      default: o.r = '0;
    endcase
    o.z = (o.r == 32'd0);
    return o;
  endfunction

  // {ALU_control, bonus_control} the ALU expects for each operation
  function automatic logic [6:0] name2code(input int name);
    case (name)
      N_AND:  return 7'b0000_000;
      N_OR:   return 7'b0001_000;
      N_ADD:  return 7'b0010_000;
      N_SUB:  return 7'b0110_000;
      N_SLT:  return 7'b0111_000;
      N_NOR:  return 7'b1100_000;
      N_NAND: return 7'b1101_000;
      N_SLL:  return 7'b1000_000;
      N_SRL:  return 7'b1001_000;
      N_SGT:  return 7'b0111_001;
      N_SLE:  return 7'b0111_010;
      N_SGE:  return 7'b0111_011;
      N_SEQ:  return 7'b0111_110;
      N_SNE:  return 7'b0111_100;
      default: return 7'b1111_111;
    endcase
  endfunction

  function automatic int code2name(input logic [6:0] code);
    for (int n = 0; n <= N_LAST; n++)
      if (name2code(n) == code) return n;
    return N_BAD;
  endfunction

  function automatic int req2name(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b00) return N_ADD;
    if (op == 2'b01) return N_SUB;
    if (op == 2'b11) return N_SLT;
    case (fn)
      6'h20: return N_ADD;
      6'h22: return N_SUB;
      6'h24: return N_AND;
      6'h25: return N_OR;
      6'h27: return N_NOR;
      6'h26: return N_NAND;
      6'h2A: return N_SLT;
      6'h00: return N_SLL;
      6'h02: return N_SRL;
`ifdef BONUS_CMP_EN
      6'h38: return N_SGT;
      6'h39: return N_SLE;
      6'h3A: return N_SGE;
      6'h3B: return N_SEQ;
      6'h3C: return N_SNE;
`endif
      default: return N_BAD;
    endcase
  endfunction

  // ---------------- behavioural ALU on the issue side ----------------
  alu_out_t dev;
  assign dev = ref_calc(code2name({alu_control_o, alu_bonus_o}), alu_src1_o, alu_src2_o);
  assign alu_result_i   = dev.r;
  assign alu_zero_i     = dev.z;
  assign alu_cout_i     = dev.c;
  assign alu_overflow_i = dev.v;

  // ---------------- reference model ----------------
  // m_age: -1 when idle, else edges since the accepting edge.
  // Response valid once m_age reaches the latency (2 legal, 1 illegal).
  int            m_age = -1;
  int            m_lat = 2;
  logic [CW-1:0] m_cnt = '0;
  logic [31:0]   m_src1 = '0, m_src2 = '0;
  logic [6:0]    m_code = '0;
  alu_out_t      m_out = '0;
  logic          m_ill = 1'b0;

  always @(posedge clk_i or posedge rst_i) begin
    int nm;
    if (rst_i) begin
      m_age = -1; m_cnt = '0; m_src1 = '0; m_src2 = '0; m_code = '0;
      m_out = '0; m_ill = 1'b0; m_lat = 2;
    end else if (m_age < 0) begin
      if (in_valid_i) begin
        m_cnt = m_cnt + 1'b1;
        m_age = 1;
        nm = req2name(alu_op_i, funct_i);
        if (nm == N_BAD) begin
          m_out = '0; m_ill = 1'b1; m_lat = 1;
        end else begin
          m_out = ref_calc(nm, src1_i, src2_i); m_ill = 1'b0; m_lat = 2;
          m_src1 = src1_i; m_src2 = src2_i; m_code = name2code(nm);
        end
      end
    end else if (m_age >= m_lat) begin
      if (out_ready_i) m_age = -1;
    end else begin
      m_age = m_age + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk_i) begin
    logic mv;
    mv = (m_age >= m_lat);
    chk("in_ready", 32'(in_ready_o), 32'(!rst_i && m_age < 0));
    chk("out_valid", 32'(out_valid_o), 32'(mv));
    chk("op_cnt", 32'(op_cnt_o), 32'(m_cnt));
    chk("alu_rst_n", 32'(alu_rst_n_o), 32'(!rst_i));
    chk("alu_src1", alu_src1_o, m_src1);
    chk("alu_src2", alu_src2_o, m_src2);
    chk("alu_code", 32'({alu_control_o, alu_bonus_o}), 32'(m_code));
    if (mv) begin
      chk("out_result", out_result_o, m_out.r);
      chk("out_flags", 32'({out_zero_o, out_cout_o, out_overflow_o, out_illegal_o}),
          32'({m_out.z, m_out.c, m_out.v, m_ill}));
    end
  end

  // ---------------- driver ----------------
  // flags = {zero, cout, overflow, illegal}; lat = negedges after accept edge until valid
  task automatic run_op(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input int hold, input bit keep_valid,
                        output logic [31:0] res, output logic [3:0] flags, output int lat);
    int n;
    res = '0; flags = '0; lat = 0;
    @(negedge clk_i);
    alu_op_i = op; funct_i = fn; src1_i = a; src2_i = b; in_valid_i = 1'b1; out_ready_i = 1'b0;
    n = 0;
    while (!in_ready_o && n < 50) begin @(negedge clk_i); n++; end
    if (!in_ready_o) begin
      chk("accept_timeout", 32'(in_ready_o), 32'd1);
      in_valid_i = 1'b0;
      return;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    if (!keep_valid) in_valid_i = 1'b0;
    lat = 1;
    while (!out_valid_o && lat < 10) begin @(negedge clk_i); lat++; end
    if (!out_valid_o) begin
      chk("valid_timeout", 32'(out_valid_o), 32'd1);
      in_valid_i = 1'b0;
      return;
    end
    res = out_result_o;
    flags = {out_zero_o, out_cout_o, out_overflow_o, out_illegal_o};
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_i);
      chk("hold_result", out_result_o, res);
      chk("hold_flags", 32'({out_zero_o, out_cout_o, out_overflow_o, out_illegal_o}), 32'(flags));
      chk("hold_ready", 32'(in_ready_o), 32'd0);
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat;
    logic [CW-1:0] cnt0;
    logic [5:0]  fn_tab [17];
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h26, 6'h2A, 6'h00, 6'h02,
               6'h38, 6'h39, 6'h3A, 6'h3B, 6'h3C, 6'h3F, 6'h01, 6'h21};

    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_in_ready", 32'(in_ready_o), 32'd0);
    chk("rst_alu_control", 32'(alu_control_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i); #1;
    chk("post_rst_in_ready", 32'(in_ready_o), 32'd1);
    chk("post_rst_op_cnt", 32'(op_cnt_o), 32'd0);

    // 1: R-type ADD 5+7
    run_op(2'b10, 6'h20, 32'd5, 32'd7, 0, 1'b0, res, fl, lat);
    chk("t1_control", 32'(alu_control_o), 32'h2);
    chk("t1_result", res, 32'd12);
    chk("t1_zero", 32'(fl[3]), 32'd0);
    chk("t1_latency", 32'(lat), 32'd2);

    // 2: SUB equal operands
    run_op(2'b01, 6'h00, 32'h1234, 32'h1234, 1, 1'b0, res, fl, lat);
    chk("t2_control", 32'(alu_control_o), 32'h6);
    chk("t2_result", res, 32'd0);
    chk("t2_zero", 32'(fl[3]), 32'd1);

    // 3: ADD signed overflow
    run_op(2'b00, 6'h00, 32'h7FFF_FFFF, 32'h1, 0, 1'b0, res, fl, lat);
    chk("t3_result", res, 32'h8000_0000);
    chk("t3_overflow", 32'(fl[1]), 32'd1);
    chk("t3_cout", 32'(fl[2]), 32'd0);

    // 4: illegal funct
    cnt0 = op_cnt_o;
    run_op(2'b10, 6'h3F, 32'hDEAD_BEEF, 32'h1, 0, 1'b0, res, fl, lat);
    chk("t4_illegal", 32'(fl[0]), 32'd1);
    chk("t4_result", res, 32'd0);
    chk("t4_latency", 32'(lat), 32'd1);
    chk("t4_cnt", 32'(op_cnt_o), 32'(cnt0 + 1'b1));
    chk("t4_alu_control_kept", 32'(alu_control_o), 32'h2);
    chk("t4_alu_src1_kept", alu_src1_o, 32'h7FFF_FFFF);

    // 5: response held 5 cycles while in_valid stays high
    cnt0 = op_cnt_o;
    run_op(2'b00, 6'h00, 32'd2, 32'd3, 5, 1'b1, res, fl, lat);
    chk("t5_result", res, 32'd5);
    chk("t5_cnt", 32'(op_cnt_o), 32'(cnt0 + 1'b1));

    // 6: reset pulse while EXEC
    @(negedge clk_i);
    alu_op_i = 2'b00; src1_i = 32'd1; src2_i = 32'd2; in_valid_i = 1'b1;
    @(posedge clk_i);
    #2 rst_i = 1'b1; in_valid_i = 1'b0;
    #1;
    chk("t6_out_valid", 32'(out_valid_o), 32'd0);
    chk("t6_in_ready", 32'(in_ready_o), 32'd0);
    chk("t6_op_cnt", 32'(op_cnt_o), 32'd0);
    chk("t6_alu_src1", alu_src1_o, 32'd0);
    chk("t6_alu_rst_n", 32'(alu_rst_n_o), 32'd0);
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    @(negedge clk_i); #1;
    chk("t6_rel_in_ready", 32'(in_ready_o), 32'd1);
    chk("t6_rel_op_cnt", 32'(op_cnt_o), 32'd0);

    // 7: bonus compare SGT 9 > 3
    run_op(2'b10, 6'h38, 32'd9, 32'd3, 0, 1'b0, res, fl, lat);
`ifdef BONUS_CMP_EN
    chk("t7_control", 32'(alu_control_o), 32'h7);
    chk("t7_bonus", 32'(alu_bonus_o), 32'h1);
    chk("t7_result", res, 32'd1);
    chk("t7_illegal", 32'(fl[0]), 32'd0);
`else
    chk("t7_illegal", 32'(fl[0]), 32'd1);
    chk("t7_bonus", 32'(alu_bonus_o), 32'h0);
`endif

    // randomized run; counter wraps many times with CW=4
    for (int i = 0; i < 250; i++) begin
      run_op(2'($urandom_range(0, 3)), fn_tab[$urandom_range(0, 16)], rand_operand(),
             rand_operand(), $urandom_range(0, 3), 1'($urandom_range(0, 1)), res, fl, lat);
      chk("rand_latency", 32'(lat), 32'(fl[0] ? 1 : 2));
    end

    repeat (2) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
